// File: rtl/shift_engine_if.sv
// Request/result bundle for shift_engine: operand, mode, count and handshake.
// Flag outputs zf/vf exist only when SHIFT_ENGINE_FLAGS_EN is defined.
interface shift_engine_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] pi;
    logic             si;
    logic             hold;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             busy;
    logic             done;
`ifdef SHIFT_ENGINE_FLAGS_EN
    logic             zf;
    logic             vf;

    modport master (output start, mode, amount, pi, si, hold,
                    input  q, so, busy, done, zf, vf);
    modport slave  (input  start, mode, amount, pi, si, hold,
                    output q, so, busy, done, zf, vf);
`else
    modport master (output start, mode, amount, pi, si, hold,
                    input  q, so, busy, done);
    modport slave  (input  start, mode, amount, pi, si, hold,
                    output q, so, busy, done);
`endif
endinterface

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine: one single-bit step per clock, start/busy/done handshake.
// Optional zero/overflow flags are built when SHIFT_ENGINE_FLAGS_EN is defined.
module shift_engine #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           r,
    shift_engine_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // Returns {so, q} after one step; unassigned modes leave both untouched.
    function automatic logic [WIDTH:0] step_f(input logic [WIDTH-1:0] q_in,
                                              input logic             so_in,
                                              input logic             fill,
                                              input logic [2:0]       m);
        logic [WIDTH:0] res;
        case (m)
            MODE_LSL: res = {q_in[WIDTH-1], q_in[WIDTH-2:0], fill};
            MODE_LSR: res = {q_in[0], fill, q_in[WIDTH-1:1]};
            MODE_ASR: res = {q_in[0], q_in[WIDTH-1], q_in[WIDTH-1:1]};
            MODE_ROL: res = {q_in[WIDTH-1], q_in[WIDTH-2:0], q_in[WIDTH-1]};
            MODE_ROR: res = {q_in[0], q_in[0], q_in[WIDTH-1:1]};
            default:  res = {so_in, q_in};
        endcase
        return res;
    endfunction

    state_t           state_r, state_s;
    logic [AMT_W-1:0] count_r, count_s;
    logic [2:0]       mode_r,  mode_s;
    logic [WIDTH-1:0] q_r,     q_s;
    logic             so_r,    so_s;
    logic             busy_r,  busy_s;
    logic             done_r,  done_s;
    logic [WIDTH:0]   step_s;

    assign step_s = step_f(q_r, so_r, bus.si, mode_r);

`ifdef SHIFT_ENGINE_FLAGS_EN
    logic zf_r, zf_s;
    logic vf_r, vf_s;
    logic lossy_s;

    // Only the non-rotating shifts can lose bits off the end.
    assign lossy_s = (mode_r == MODE_LSL) || (mode_r == MODE_LSR) || (mode_r == MODE_ASR);
`endif

    // Next-state, datapath step and output decode.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        mode_s  = mode_r;
        q_s     = q_r;
        so_s    = so_r;
`ifdef SHIFT_ENGINE_FLAGS_EN
        zf_s    = zf_r;
        vf_s    = vf_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    q_s     = bus.pi;
                    count_s = bus.amount;
                    mode_s  = bus.mode;
                    state_s = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
`ifdef SHIFT_ENGINE_FLAGS_EN
                    vf_s    = 1'b0;
                    // A zero count goes straight to DONE, so the flag is decided here.
                    zf_s    = (bus.amount == '0) ? (bus.pi == '0) : 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.hold) begin
                    state_s = ST_SHIFT;
                end else begin
                    q_s     = step_s[WIDTH-1:0];
                    so_s    = step_s[WIDTH];
                    count_s = count_r - AMT_W'(1'b1);
`ifdef SHIFT_ENGINE_FLAGS_EN
                    if (lossy_s) begin
                        vf_s = vf_r | step_s[WIDTH];
                    end else begin
                        vf_s = vf_r;
                    end
`endif
                    if (count_r == AMT_W'(1'b1)) begin
                        state_s = ST_DONE;
`ifdef SHIFT_ENGINE_FLAGS_EN
                        zf_s    = (step_s[WIDTH-1:0] == '0);
`endif
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s == ST_SHIFT);
        done_s = (state_s == ST_DONE);
    end

    // State and result registers.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            mode_r  <= 3'b000;
            q_r     <= '0;
            so_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            mode_r  <= mode_s;
            q_r     <= q_s;
            so_r    <= so_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.so   = so_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

`ifdef SHIFT_ENGINE_FLAGS_EN
    // Flag registers.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            zf_r <= 1'b0;
            vf_r <= 1'b0;
        end else begin
            zf_r <= zf_s;
            vf_r <= vf_s;
        end
    end

    assign bus.zf = zf_r;
    assign bus.vf = vf_r;
`endif
endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine at WIDTH=8: a reference model queues expected results
// at start, the done-watcher pops and compares them; flags checked under SHIFT_ENGINE_FLAGS_EN.
module tb_shift_engine;
    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic       zf;
        logic       vf;
    } exp_t;

    logic clk = 1'b0;
    logic r   = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic model_so = 1'b0;
    exp_t sb[$];

    shift_engine_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {vf, so, q} after k literal single-bit steps.
    function automatic logic [9:0] ref_op(input logic [2:0] m, input int k, input logic [7:0] a,
                                          input logic s, input logic so_in);
        int v    = int'(a);
        int o    = int'(so_in);
        int vf   = 0;
        int fill = int'(s);
        for (int i = 0; i < k; i++) begin
            case (m)
                3'd0: begin o = (v >> 7) & 1; v = ((v << 1) | fill) & 255; vf = vf | o; end
                3'd1: begin o = v & 1; v = (v >> 1) | (fill << 7); vf = vf | o; end
                3'd2: begin o = v & 1; v = (v >> 1) | (v & 128); vf = vf | o; end
                3'd3: begin o = (v >> 7) & 1; v = ((v << 1) | o) & 255; end
                3'd4: begin o = v & 1; v = (v >> 1) | (o << 7); end
                default: ;
            endcase
        end
        return {vf[0], o[0], v[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] m, input logic [3:0] k, input logic [7:0] a,
                          input logic s, input int hold_at, input int hold_n,
                          input logic poke, input logic [7:0] frozen_q);
        logic [9:0] res;
        exp_t       e;
        int         cyc;
        int         busy_n;
        int         exp_lat;
        exp_lat = int'(k) + hold_n;
        res  = ref_op(m, int'(k), a, s, model_so);
        e.q  = res[7:0];
        e.so = res[8];
        e.vf = res[9];
        e.zf = (res[7:0] == 8'h00);
        model_so = res[8];
        sb.push_back(e);
        bus.mode   = m;
        bus.amount = k;
        bus.pi     = a;
        bus.si     = s;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.pi     = ~a;
        bus.mode   = m ^ 3'b001;
        bus.amount = k + 4'd1;
        cyc    = 0;
        busy_n = 0;
        while (!bus.done && cyc < 60) begin
            if (bus.busy) busy_n++;
            if (hold_n > 0 && cyc > hold_at && cyc <= hold_at + hold_n)
                check_eq("hold_q", 32'(bus.q), 32'(frozen_q));
            if (hold_n > 0 && cyc == hold_at) bus.hold = 1'b1;
            if (hold_n > 0 && cyc == hold_at + hold_n) bus.hold = 1'b0;
            if (poke && cyc == 1) begin
                bus.pi = 8'h5A; bus.amount = 4'd1; bus.mode = 3'd3; bus.start = 1'b1;
            end
            if (poke && cyc == 2) bus.start = 1'b0;
            tick();
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("busy_cycles", 32'(busy_n), 32'(exp_lat));
        tick();
        check_eq("done_1cyc", 32'(bus.done), 32'd0);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    // Pops and compares the expected result whenever done is presented.
    always @(negedge clk) begin
        if (!r && bus.done) begin
            check_eq("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("res_q", 32'(bus.q), 32'(e.q));
                check_eq("res_so", 32'(bus.so), 32'(e.so));
`ifdef SHIFT_ENGINE_FLAGS_EN
                check_eq("res_zf", 32'(bus.zf), 32'(e.zf));
                check_eq("res_vf", 32'(bus.vf), 32'(e.vf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.mode = 3'd0; bus.amount = 4'd0;
        bus.pi = 8'h00;   bus.si = 1'b0;   bus.hold = 1'b0;
        repeat (3) tick();
        check_eq("rst_q", 32'(bus.q), 32'd0);
        check_eq("rst_so", 32'(bus.so), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        r = 1'b0;
        tick();

        // Reset in the middle of an LSL 0xFF by 5, after two steps.
        bus.mode = 3'd0; bus.amount = 4'd5; bus.pi = 8'hFF; bus.si = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check_eq("mid_q", 32'(bus.q), 32'h0000_00FC);
        check_eq("mid_busy", 32'(bus.busy), 32'd1);
        #2 r = 1'b1;
        #1;
        check_eq("arst_q", 32'(bus.q), 32'd0);
        check_eq("arst_so", 32'(bus.so), 32'd0);
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_done", 32'(bus.done), 32'd0);
        model_so = 1'b0;
        tick();
        r = 1'b0;
        tick();

        run_op(3'd0, 4'd3, 8'h81, 1'b0, 0, 0, 1'b1, 8'h00);
        check_eq("lsl_q", 32'(bus.q), 32'h08);
        run_op(3'd2, 4'd2, 8'h90, 1'b0, 0, 0, 1'b0, 8'h00);
        check_eq("asr_q", 32'(bus.q), 32'hE4);
        run_op(3'd4, 4'd1, 8'h01, 1'b0, 0, 0, 1'b0, 8'h00);
        check_eq("ror_so", 32'(bus.so), 32'd1);
        run_op(3'd3, 4'd8, 8'hA5, 1'b0, 0, 0, 1'b0, 8'h00);
        check_eq("rol8_q", 32'(bus.q), 32'hA5);
        run_op(3'd4, 4'd0, 8'h3C, 1'b0, 0, 0, 1'b0, 8'h00);
        check_eq("amt0_q", 32'(bus.q), 32'h3C);
        run_op(3'd1, 4'd4, 8'hF0, 1'b0, 1, 2, 1'b0, 8'h78);
        check_eq("lsr_hold_q", 32'(bus.q), 32'h0F);
        run_op(3'd0, 4'd12, 8'hFF, 1'b1, 0, 0, 1'b0, 8'h00);
        run_op(3'd1, 4'd10, 8'hA5, 1'b0, 0, 0, 1'b0, 8'h00);
        run_op(3'd4, 4'd11, 8'h96, 1'b0, 0, 0, 1'b0, 8'h00);
        check_eq("ror11_q", 32'(bus.q), 32'hD2);
        run_op(3'd6, 4'd3, 8'h5A, 1'b1, 0, 0, 1'b0, 8'h00);
        run_op(3'd0, 4'd1, 8'h80, 1'b0, 0, 0, 1'b0, 8'h00);
        run_op(3'd3, 4'd1, 8'h80, 1'b0, 0, 0, 1'b0, 8'h00);
        check_eq("rol1_q", 32'(bus.q), 32'h01);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
